// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: PC-select encodings,
// fetch FSM states and the word shown to the decoder when nothing is valid.
package instr_fetch_unit_pkg;

  // PC select driven by the decoder alongside an accepted instruction
  typedef enum logic [1:0] {
    PcBrImm  = 2'b00,
    PcBrAcc  = 2'b01,
    PcRepeat = 2'b10,
    PcInc    = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StReq   = 2'b01,
    StStall = 2'b10
  } fetch_state_e;

  localparam logic [15:0] NopWord = 16'h0000;

endpackage

// File: rtl/instr_fetch_unit_queue.sv
// fetch_queue: small synchronous FIFO holding {instruction, pc} entries.
// Flush wins over push; Depth must be a power of two so pointers wrap freely.
module fetch_queue #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 28,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [Width-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [CntW-1:0]  count
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  // Occupancy flags and qualified push/pop (push into a full queue only with a pop)
  always_comb begin
    full      = (count_q == CntW'(Depth));
    empty     = (count_q == '0);
    do_pop    = pop & ~empty;
    do_push   = push & (~full | pop);
    head_data = mem_q[rd_ptr_q];
    count     = count_q;
  end

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the fetch PC, reads program memory over req/ack,
// buffers words in fetch_queue and issues the head to the decoder.
// Optional macro IFU_PERF_CNT_EN adds saturating stall_cnt/flush_cnt outputs.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 12,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                pmem_req,
  output logic [PC_WIDTH-1:0] pmem_addr,
  input  logic                pmem_ack,
  input  logic [15:0]         pmem_rdata,
  output logic [15:0]         instruction,
  output logic [7:0]          OP_dk,
  output logic [3:0]          OP_s,
  output logic [PC_WIDTH-1:0] issue_pc,
  output logic                instr_valid,
  input  logic                instr_ready,
  input  logic [1:0]          pcInMux_ctrl,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic [PC_WIDTH-1:0] acc_target
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [15:0]         stall_cnt,
  output logic [15:0]         flush_cnt
`endif
);

  localparam int unsigned CntW   = $clog2(QDEPTH) + 1;
  localparam int unsigned EntryW = 16 + PC_WIDTH;

  fetch_state_e        state_q;
  logic [PC_WIDTH-1:0] fetch_pc_q, req_addr_q;
  logic                req_q, kill_q;

  logic [EntryW-1:0]   q_head;
  logic                q_full, q_empty;
  logic [CntW-1:0]     q_count, cnt_next;
  logic                accept, redirect, push, pop;
  logic [PC_WIDTH-1:0] target, pc_after_ack;

  // Issue decode and next-occupancy used to throttle new requests
  always_comb begin
    accept       = instr_valid & instr_ready;
    redirect     = accept & ((pcInMux_ctrl == PcBrImm) | (pcInMux_ctrl == PcBrAcc));
    pop          = accept & (pcInMux_ctrl != PcRepeat);
    target       = (pcInMux_ctrl == PcBrAcc) ? acc_target : branch_target;
    // Killed data and data landing in the redirect cycle are both dropped
    push         = (state_q == StReq) & pmem_ack & ~kill_q & ~redirect;
    cnt_next     = redirect ? '0 : q_count + CntW'(push) - CntW'(pop);
    // While killed, fetch_pc_q already holds the redirect target
    pc_after_ack = redirect ? target : (kill_q ? fetch_pc_q : fetch_pc_q + PC_WIDTH'(1));
  end

  // Fetch FSM with registered request/address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      req_q      <= 1'b0;
      req_addr_q <= '0;
      fetch_pc_q <= '0;
      kill_q     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          state_q    <= StReq;
          req_q      <= 1'b1;
          req_addr_q <= fetch_pc_q;
        end
        StReq: begin
          if (pmem_ack) begin
            fetch_pc_q <= pc_after_ack;
            kill_q     <= 1'b0;
            if (cnt_next < CntW'(QDEPTH)) begin
              req_addr_q <= pc_after_ack;
            end else begin
              state_q <= StStall;
              req_q   <= 1'b0;
            end
          end else if (redirect) begin
            // Request stays up until acked; its data is thrown away
            kill_q     <= 1'b1;
            fetch_pc_q <= target;
          end
        end
        StStall: begin
          if (redirect) begin
            fetch_pc_q <= target;
          end
          if (~q_full | redirect) begin
            state_q    <= StReq;
            req_q      <= 1'b1;
            req_addr_q <= redirect ? target : fetch_pc_q;
          end
        end
        default: begin
          state_q <= StIdle;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  fetch_queue #(
    .Depth (QDEPTH),
    .Width (EntryW)
  ) u_fetch_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({pmem_rdata, req_addr_q}),
    .pop       (pop),
    .flush     (redirect),
    .head_data (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  // Decoder-facing outputs come straight from the queue head flops
  always_comb begin
    pmem_req    = req_q;
    pmem_addr   = req_addr_q;
    instr_valid = ~q_empty;
    instruction = instr_valid ? q_head[EntryW-1:PC_WIDTH] : NopWord;
    issue_pc    = instr_valid ? q_head[PC_WIDTH-1:0] : '0;
    OP_dk       = instruction[15:8];
    OP_s        = instruction[15:12];
  end

`ifdef IFU_PERF_CNT_EN
  // Saturating counters: decoder starved cycles and redirect accepts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (~instr_valid & instr_ready & (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if (redirect & (flush_cnt != 16'hFFFF)) begin
        flush_cnt <= flush_cnt + 16'd1;
      end
    end
  end
`else
  // Counters not built
`endif

endmodule
